// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states
//   WORD          : datapath / PC width
//   INSTR_LEN     : instruction width
//   PC_INC        : sequential PC step in bytes
//   BR_SHIFT      : branch offsets are in words; shift to get bytes
package fetch_pkg;
  localparam int WORD      = 64;
  localparam int INSTR_LEN = 32;
  localparam int PC_INC    = 4;
  localparam int BR_SHIFT  = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FULL  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/ifetch_stage_if.sv
// Instruction-memory request/response bus.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : byte address, stable while imem_req=1 until imem_ready
//   imem_ready : response valid, only meaningful while imem_req=1
//   imem_rdata : instruction word, valid with imem_ready
interface ifetch_stage_if #(
  parameter int WORD      = fetch_pkg::WORD,
  parameter int INSTR_LEN = fetch_pkg::INSTR_LEN
);
  logic                 imem_req;
  logic [WORD-1:0]      imem_addr;
  logic                 imem_ready;
  logic [INSTR_LEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection.
//   pc                   : current fetch PC
//   id_pc                : PC of the instruction in IF/ID (branch base)
//   sign_extended_output : branch offset in words
//   redirect             : take the branch target
//   pc_plus4             : sequential successor (wraps modulo 2^WORD)
//   target               : id_pc + offset*4, overflow bits discarded
//   next_pc              : target when redirect, else pc_plus4
module pc_next_calc
  import fetch_pkg::*;
#(
  parameter int WORD = fetch_pkg::WORD
) (
  input  logic [WORD-1:0] pc,
  input  logic [WORD-1:0] id_pc,
  input  logic [WORD-1:0] sign_extended_output,
  input  logic            redirect,
  output logic [WORD-1:0] pc_plus4,
  output logic [WORD-1:0] target,
  output logic [WORD-1:0] next_pc
);
  assign pc_plus4 = pc + WORD'(PC_INC);
  assign target   = id_pc + (sign_extended_output << BR_SHIFT);
  assign next_pc  = redirect ? target : pc_plus4;
endmodule

// File: rtl/ifetch_stage.sv
// LEGv8 instruction-fetch stage: owns the PC, fetches over a req/ready bus,
// and feeds iDecode through an IF/ID register with stall/flush.
//   clk, rst_n                 : clock, synchronous active-low reset
//   stall                      : decode cannot accept; IF/ID holds
//   uncondbranch, branch, zero : branch resolution for the instruction in ID
//   sign_extended_output       : branch offset in words
//   imem                       : instruction-memory bus (master side)
//   instruction, id_pc, id_valid : IF/ID register to iDecode
module ifetch_stage
  import fetch_pkg::*;
#(
  parameter int              WORD      = fetch_pkg::WORD,
  parameter int              INSTR_LEN = fetch_pkg::INSTR_LEN,
  parameter logic [WORD-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall,
  input  logic                 uncondbranch,
  input  logic                 branch,
  input  logic                 zero,
  input  logic [WORD-1:0]      sign_extended_output,
  ifetch_stage_if.master       imem,
  output logic [INSTR_LEN-1:0] instruction,
  output logic [WORD-1:0]      id_pc,
  output logic                 id_valid
);
  fetch_state_t         state_q;
  logic [WORD-1:0]      pc_q, addr_q;
  logic                 req_q;
  logic [INSTR_LEN-1:0] instr_q, skid_q;
  logic [WORD-1:0]      id_pc_q, skid_pc_q;
  logic                 id_valid_q;

  logic                 redirect_d;
  logic [WORD-1:0]      pc_plus4_d, target_d, next_pc_d;

  // A branch in ID only resolves once decode accepts it; while stalled it
  // simply waits in IF/ID and redirects later.
  assign redirect_d = id_valid_q & ~stall & (uncondbranch | (branch & zero));

  pc_next_calc #(.WORD(WORD)) u_pc_next (
    .pc                   (pc_q),
    .id_pc                (id_pc_q),
    .sign_extended_output (sign_extended_output),
    .redirect             (redirect_d),
    .pc_plus4             (pc_plus4_d),
    .target               (target_d),
    .next_pc              (next_pc_d)
  );

  // addr_q is separate from pc_q so DRAIN can keep presenting the abandoned
  // address while pc_q already points at the branch target.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
      instr_q    <= '0;
      id_pc_q    <= '0;
      id_valid_q <= 1'b0;
      skid_q     <= '0;
      skid_pc_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= FETCH;
          req_q   <= 1'b1;
          addr_q  <= pc_q;
        end
        FETCH: begin
          if (redirect_d || imem.imem_ready) pc_q <= next_pc_d;
          if (redirect_d) begin
            id_valid_q <= 1'b0;
            instr_q    <= '0;
            skid_q     <= '0;
            skid_pc_q  <= '0;
            // Unacknowledged request must still complete: drain it first.
            if (imem.imem_ready) addr_q <= target_d;
            else                 state_q <= DRAIN;
          end else if (imem.imem_ready) begin
            if (stall) begin
              skid_q    <= imem.imem_rdata;
              skid_pc_q <= pc_q;
              req_q     <= 1'b0;
              state_q   <= FULL;
            end else begin
              instr_q    <= imem.imem_rdata;
              id_pc_q    <= pc_q;
              id_valid_q <= 1'b1;
              addr_q     <= pc_plus4_d;
            end
          end
        end
        FULL: begin
          if (redirect_d) begin
            pc_q       <= target_d;
            addr_q     <= target_d;
            id_valid_q <= 1'b0;
            instr_q    <= '0;
          end else if (!stall) begin
            instr_q    <= skid_q;
            id_pc_q    <= skid_pc_q;
            id_valid_q <= 1'b1;
            addr_q     <= pc_q;
          end
          if (redirect_d || !stall) begin
            skid_q    <= '0;
            skid_pc_q <= '0;
            req_q     <= 1'b1;
            state_q   <= FETCH;
          end
        end
        DRAIN: begin
          if (imem.imem_ready) begin
            state_q <= FETCH;
            addr_q  <= pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instruction    = instr_q;
  assign id_pc          = id_pc_q;
  assign id_valid       = id_valid_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (RESET_PC[1:0] == 2'b00) else $error("RESET_PC not word aligned");
      assert (pc_q[1:0] == 2'b00) else $error("pc not word aligned");
    end
  end
endmodule

// File: doc/ifetch_stage.md
Name: ifetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 core; sits directly upstream of iDecode.
- Owns the PC and requests 32-bit instructions from instruction memory with a req/ready handshake.
- Presents the fetched instruction to iDecode through an IF/ID register with valid, stall and flush.
- Resolves redirects for B/CBZ/CBNZ from the decode outputs uncondbranch, branch and sign_extended_output, plus a zero flag.

Parameters:
- WORD, 64, datapath/PC width.
- INSTR_LEN, 32, instruction width.
- RESET_PC, 64'h0, PC after reset; must be a multiple of 4.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- stall  in  1  decode cannot accept; hold IF/ID.
- uncondbranch  in  1  from decode: B in ID.
- branch  in  1  from decode: CBZ/CBNZ in ID.
- zero  in  1  branch condition true for the instruction in ID.
- sign_extended_output  in  WORD  from decode: branch offset in words.
- imem_req  out  1  fetch request.
- imem_addr  out  WORD  byte address of the fetch.
- imem_ready  in  1  response valid; only meaningful while imem_req=1.
- imem_rdata  in  INSTR_LEN  instruction; valid when imem_ready=1.
- instruction  out  INSTR_LEN  IF/ID instruction to iDecode.
- id_pc  out  WORD  PC of `instruction`.
- id_valid  out  1  IF/ID holds a real instruction.

Behaviour:
- Reset (synchronous, rst_n low at a rising edge):
  - pc=RESET_PC, instruction=0, id_pc=0, id_valid=0, imem_req=0, skid empty, state=IDLE.
  - Reset mid-handshake abandons the request. Memory must tolerate a dropped req.
- FSM states: IDLE, FETCH, FULL, DRAIN.
- IDLE: imem_req=0. Go to FETCH unconditionally on the next cycle.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - req and addr stay stable until imem_ready is sampled high; any number of wait cycles is allowed.
- Accept = FETCH & imem_ready & !stall & !redirect:
  - instruction<=imem_rdata, id_pc<=pc, id_valid<=1, pc<=pc+4. Stay in FETCH.
  - With zero wait states this gives one instruction per cycle.
- Response while stall=1 (and no redirect):
  - skid<=imem_rdata, skid_pc<=pc, pc<=pc+4. Go to FULL.
  - IF/ID holds its contents.
- FULL:
  - imem_req=0.
  - When stall=0: IF/ID<=skid, id_valid<=1, then go to FETCH.
  - Load-to-use fetch latency after a stall is therefore 1 cycle.
- IF/ID while stall=1: instruction, id_pc and id_valid hold in every state.
- Redirect:
  - redirect = id_valid & !stall & (uncondbranch | (branch & zero)).
  - target = id_pc + (sign_extended_output << 2), modulo 2^WORD; bits shifted out are discarded.
- On redirect:
  - pc<=target, id_valid<=0, instruction<=0 (flush), skid cleared.
  - FETCH with imem_ready=1 in the same cycle: response discarded, stay in FETCH at target.
  - FETCH with imem_ready=0: go to DRAIN.
  - FULL: skid discarded, go to FETCH.
- DRAIN:
  - imem_req=1 with the old address held.
  - When imem_ready: discard data, go to FETCH (new pc).
  - A further redirect cannot occur in DRAIN because id_valid=0.
- Priorities: reset > stall > redirect > accept. A redirect with stall=1 is deferred, not lost, because the branch stays in ID.
- PC arithmetic:
  - pc+4 wraps from 2^64-4 to 0 silently.
  - pc[1:0] is always 00.
  - Simulation assertion fires if RESET_PC[1:0]!=0.
- imem_req is never asserted in IDLE or FULL. The outstanding count is always ≤1.

Decomposition:
- Shared package fetch_pkg:
  - fetch_state_t enum (IDLE, FETCH, FULL, DRAIN).
  - INSTR_LEN/WORD localparams, mirroring the existing `INSTR_LEN`/`WORD` defines.
  - PC_INC=4.
  - BR_SHIFT=2.
- Sub-module pc_next_calc (combinational):
  - Inputs: pc, id_pc, sign_extended_output, redirect.
  - Outputs: pc_plus4, target, next_pc.
  - Unit-testable alone.
- The FSM, skid and IF/ID register stay in ifetch_stage.

Test Plan:
- Sequential fetch, zero-wait memory (ready tied to req), RESET_PC=0.
  - Response: IF/ID shows id_pc 0,4,8 on consecutive cycles with id_valid=1.
  - Instruction at 0 = 32'hF84402C9.
- Wait states: ready delayed 3 cycles at addr 8.
  - Response: imem_addr held at 8 for 4 cycles; id_valid for the next instruction rises exactly one cycle after ready.
- Stall with response: stall=1 while the addr-12 fetch returns 32'h8B09026A.
  - Response: IF/ID unchanged, imem_req=0 while FULL.
  - After stall drops: instruction=32'h8B09026A, id_pc=12, next addr 16.
- Taken branch, B -55 at id_pc=0x100 (uncondbranch=1, offset=-55).
  - Response: next imem_addr=0x100-220=0x24, id_valid=0 for one cycle.
  - CBZ with zero=0: no redirect.
- Redirect during an unacknowledged request: redirect to 0x40 while the addr-0x20 request is pending 2 more cycles.
  - Response: addr 0x20 held until ready, data discarded.
  - Then addr 0x40, and instruction from 0x20 never appears valid.
- Reset mid-operation: rst_n=0 for one edge during DRAIN.
  - Response: imem_req=0, id_valid=0 and pc=RESET_PC next cycle.
  - Wrap check: pc at 0xFFFF_FFFF_FFFF_FFFC yields 0 next.
